// File: rtl/rx_seq_pkg.sv
// Shared types and defaults for the receive sequencer.
// The sync-tolerance feature is enabled with RX_SYNC_TOL_EN.
package rx_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWEEP   = 3'd1,
    ST_HUNT    = 3'd2,
    ST_RECV    = 3'd3,
    ST_RESTART = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } rx_state_t;

  localparam int          DEF_SYNC_LEN  = 16;
  localparam logic [15:0] DEF_SYNC_WORD = 16'h2DD4;

  // Number of set bits; used as a Hamming distance when compared against the sync word.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rx_seq_ctrl_packer.sv
// rx_bit_packer: packs a bit stream MSB first into bytes, one-cycle byte_valid strobe.
// clear drops any partially assembled byte.
module rx_bit_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  logic [6:0] shift_reg;
  logic [2:0] cnt_reg;
  logic [7:0] byte_data_reg;
  logic       byte_valid_reg;

  // Shift bits in; on the 8th bit present the completed byte on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg      <= '0;
      cnt_reg        <= '0;
      byte_data_reg  <= '0;
      byte_valid_reg <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      if (clear) begin
        shift_reg <= '0;
        cnt_reg   <= '0;
      end else if (bit_valid) begin
        shift_reg <= {shift_reg[5:0], bit_in};
        cnt_reg   <= cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          byte_data_reg  <= {shift_reg, bit_in};
          byte_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign byte_data  = byte_data_reg;
  assign byte_valid = byte_valid_reg;

endmodule

// File: rtl/rx_seq_ctrl.sv
// rx_seq_ctrl: downmixer sweep, sync hunt and payload capture sequencer.
// Define RX_SYNC_TOL_EN to accept a sync word with one bit error and add sync_err.
module rx_seq_ctrl
  import rx_seq_pkg::*;
#(
  parameter int                  SYNC_LEN          = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD         = DEF_SYNC_WORD,
  parameter int                  PAYLOAD_BYTES     = 8,
  parameter int                  SWEEP_TIMEOUT     = 640000,
  parameter int                  SYNC_TIMEOUT_BITS = 256,
  parameter int                  MAX_RETRY         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       sweep_done,
  input  logic       bit_strobe,
  input  logic       bit_in,
  output logic       mix_en,
  output logic       demod_start,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] retry_cnt
`ifdef RX_SYNC_TOL_EN
  ,
  output logic       sync_err
`endif
);

  localparam int SW = $clog2(SWEEP_TIMEOUT);
  localparam int BW = $clog2(SYNC_TIMEOUT_BITS);
  localparam int PW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEP_TIMEOUT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(SYNC_TIMEOUT_BITS - 1);
  localparam logic [BW-1:0] SYNC_MIN   = BW'(SYNC_LEN - 1);
  localparam logic [PW-1:0] PAY_LAST   = PW'(PAYLOAD_BYTES - 1);
  localparam logic [1:0]    RETRY_MAX  = 2'(MAX_RETRY);

  rx_state_t           state_reg, state_next;
  logic [SW-1:0]       sweep_cnt_reg, sweep_cnt_next;
  logic [BW-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [SYNC_LEN-1:0] hunt_reg, hunt_next, hunt_shifted;
  logic [PW-1:0]       byte_cnt_reg, byte_cnt_next;
  logic [1:0]          retry_reg, retry_next;
  logic                error_reg, error_next;
  logic                sync_err_reg, sync_err_next;
  logic                mix_en_reg, demod_start_reg, busy_reg, done_reg;
  logic                sync_exact, sync_hit;
  logic                pk_clear, pk_bit_valid, pk_byte_valid;

  assign hunt_shifted = {hunt_reg[SYNC_LEN-2:0], bit_in};
  assign sync_exact   = (hunt_shifted == SYNC_WORD);
`ifdef RX_SYNC_TOL_EN
  assign sync_hit = (bit_cnt_reg >= SYNC_MIN) &&
                    (popcount16(16'(hunt_shifted ^ SYNC_WORD)) <= 5'd1);
`else
  assign sync_hit = (bit_cnt_reg >= SYNC_MIN) && sync_exact;
`endif

  // The packer is held clear outside RECV so every reception starts byte-aligned,
  // and an abort discards any byte still being assembled.
  assign pk_clear     = (state_reg != ST_RECV) || abort;
  assign pk_bit_valid = (state_reg == ST_RECV) && bit_strobe && !abort;

  rx_bit_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .bit_valid  (pk_bit_valid),
    .bit_in     (bit_in),
    .byte_data  (byte_data),
    .byte_valid (pk_byte_valid)
  );

  // Next-state and counter logic; abort overrides every transition at the end.
  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    hunt_next      = hunt_reg;
    byte_cnt_next  = byte_cnt_reg;
    retry_next     = retry_reg;
    error_next     = error_reg;
    sync_err_next  = sync_err_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next     = ST_SWEEP;
          sweep_cnt_next = '0;
          retry_next     = '0;
          error_next     = 1'b0;
          sync_err_next  = 1'b0;
        end
      end
      ST_SWEEP: begin
        if (sweep_done) begin
          state_next   = ST_HUNT;
          bit_cnt_next = '0;
          hunt_next    = '0;
        end else if (sweep_cnt_reg == SWEEP_LAST) begin
          state_next = ST_RESTART;
        end else begin
          sweep_cnt_next = sweep_cnt_reg + 1'b1;
        end
      end
      ST_HUNT: begin
        if (bit_strobe) begin
          hunt_next    = hunt_shifted;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (sync_hit) begin
            state_next    = ST_RECV;
            byte_cnt_next = '0;
            sync_err_next = !sync_exact;
          end else if (bit_cnt_reg == BIT_LAST) begin
            state_next = ST_RESTART;
          end
        end
      end
      ST_RECV: begin
        if (pk_byte_valid) begin
          if (byte_cnt_reg == PAY_LAST) begin
            state_next = ST_DONE;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
          end
        end
      end
      ST_RESTART: begin
        if (retry_reg == RETRY_MAX) begin
          state_next = ST_ERROR;
        end else begin
          state_next     = ST_SWEEP;
          retry_next     = retry_reg + 2'd1;
          sweep_cnt_next = '0;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ERROR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
    end
    if (state_next == ST_ERROR) begin
      error_next = 1'b1;
    end
  end

  // State, counters and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      sweep_cnt_reg   <= '0;
      bit_cnt_reg     <= '0;
      hunt_reg        <= '0;
      byte_cnt_reg    <= '0;
      retry_reg       <= '0;
      error_reg       <= 1'b0;
      sync_err_reg    <= 1'b0;
      mix_en_reg      <= 1'b0;
      demod_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sweep_cnt_reg   <= sweep_cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      hunt_reg        <= hunt_next;
      byte_cnt_reg    <= byte_cnt_next;
      retry_reg       <= retry_next;
      error_reg       <= error_next;
      sync_err_reg    <= sync_err_next;
      mix_en_reg      <= (state_next == ST_SWEEP) || (state_next == ST_HUNT) ||
                         (state_next == ST_RECV);
      demod_start_reg <= (state_next == ST_HUNT) || (state_next == ST_RECV);
      busy_reg        <= (state_next != ST_IDLE);
      done_reg        <= (state_next == ST_DONE);
    end
  end

  assign mix_en      = mix_en_reg;
  assign demod_start = demod_start_reg;
  assign byte_valid  = pk_byte_valid;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign error       = error_reg;
  assign retry_cnt   = retry_reg;
`ifdef RX_SYNC_TOL_EN
  assign sync_err    = sync_err_reg;
`else
  logic unused_sync_err;
  assign unused_sync_err = sync_err_reg;
`endif

endmodule

// File: tb/tb_rx_seq_ctrl.sv
// Self-checking bench for rx_seq_ctrl: cycle vector table plus multi-cycle sequences.
// Also exercises sync_err when built with RX_SYNC_TOL_EN.
module tb_rx_seq_ctrl;

  localparam int SWEEP_TO = 2000;

  logic       clk = 1'b0;
  logic       rst, start, abort, sweep_done, bit_strobe, bit_in;
  logic       mix_en, demod_start, byte_valid, busy, done, error;
  logic [7:0] byte_data;
  logic [1:0] retry_cnt;
`ifdef RX_SYNC_TOL_EN
  logic       sync_err;
`endif

  int tests    = 0;
  int failures = 0;

  logic [7:0] rx_bytes[$];
  int done_cnt    = 0;
  int restart_cnt = 0;

  rx_seq_ctrl #(
    .SYNC_LEN          (16),
    .SYNC_WORD         (16'h2DD4),
    .PAYLOAD_BYTES     (8),
    .SWEEP_TIMEOUT     (SWEEP_TO),
    .SYNC_TIMEOUT_BITS (256),
    .MAX_RETRY         (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .sweep_done  (sweep_done),
    .bit_strobe  (bit_strobe),
    .bit_in      (bit_in),
    .mix_en      (mix_en),
    .demod_start (demod_start),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .retry_cnt   (retry_cnt)
`ifdef RX_SYNC_TOL_EN
    ,
    .sync_err    (sync_err)
`endif
  );

  always #5 clk = ~clk;

  // Observe outputs on the falling edge: collect bytes, done pulses and RESTART cycles.
  always @(negedge clk) begin
    if (byte_valid) rx_bytes.push_back(byte_data);
    if (done) done_cnt++;
    if (busy && !mix_en && !error && !done) restart_cnt++;
  end

  typedef struct packed {
    logic start;
    logic abort;
    logic sweep_done;
    logic bit_strobe;
    logic bit_in;
  } vin_t;

  typedef struct packed {
    logic       mix_en;
    logic       demod_start;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] retry;
  } vout_t;

  typedef struct {
    vin_t  in;
    vout_t exp;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic pulse_sweep();
    sweep_done = 1'b1;
    tick();
    sweep_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_bit(input logic b);
    bit_in     = b;
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_word(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic wait_done(input int base, input int budget);
    for (int n = 0; n < budget && done_cnt == base; n++) tick();
  endtask

  // Compare received bytes from index base against first+0 .. first+cnt-1.
  task automatic check_bytes(input string tag, input int base, input logic [7:0] first,
                             input int cnt);
    logic [7:0] got;
    check({tag, "_nbytes"}, 32'(rx_bytes.size() - base), 32'(cnt));
    for (int i = 0; i < cnt; i++) begin
      got = (base + i < rx_bytes.size()) ? rx_bytes[base + i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, first + 8'(i)});
    end
  endtask

  initial begin
    int bb, db, rb;

    // start abort sweep bs bi           mix dem busy done err retry
    vecs[0]  = '{5'b00000, 7'b0000000};  // idle stays idle
    vecs[1]  = '{5'b10000, 7'b1010000};  // start -> SWEEP
    vecs[2]  = '{5'b00000, 7'b1010000};
    vecs[3]  = '{5'b10000, 7'b1010000};  // start while busy ignored
    vecs[4]  = '{5'b00100, 7'b1110000};  // sweep_done -> HUNT
    vecs[5]  = '{5'b01000, 7'b0000000};  // abort -> IDLE
    vecs[6]  = '{5'b11000, 7'b0000000};  // abort beats start
    vecs[7]  = '{5'b00000, 7'b0000000};
    vecs[8]  = '{5'b10000, 7'b1010000};
    vecs[9]  = '{5'b01100, 7'b0000000};  // abort beats sweep_done
    vecs[10] = '{5'b10000, 7'b1010000};
    vecs[11] = '{5'b00100, 7'b1110000};
    vecs[12] = '{5'b00010, 7'b1110000};  // single bit in HUNT
    vecs[13] = '{5'b01000, 7'b0000000};

    rst = 1'b1; start = 1'b0; abort = 1'b0; sweep_done = 1'b0;
    bit_strobe = 1'b0; bit_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs",
          {19'd0, mix_en, demod_start, byte_valid, busy, done, error, retry_cnt, byte_data},
          32'd0);

    // Cycle-by-cycle control vectors
    for (int i = 0; i < 14; i++) begin
      {start, abort, sweep_done, bit_strobe, bit_in} = vecs[i].in;
      tick();
      {start, abort, sweep_done, bit_strobe, bit_in} = '0;
      check($sformatf("vec%0d", i),
            {25'd0, mix_en, demod_start, busy, done, error, retry_cnt},
            {25'd0, vecs[i].exp});
    end

    // Nominal reception
    bb = rx_bytes.size(); db = done_cnt;
    do_start();
    repeat (1000) tick();
    pulse_sweep();
    send_word(16'h2DD4);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    wait_done(db, 50);
    repeat (2) tick();
    check_bytes("nom", bb, 8'h01, 8);
    check("nom_done_pulses", 32'(done_cnt - db), 32'd1);
    check("nom_retry", {30'd0, retry_cnt}, 32'd0);
    check("nom_busy_error", {30'd0, busy, error}, 32'd0);
`ifdef RX_SYNC_TOL_EN
    check("nom_sync_err", {31'd0, sync_err}, 32'd0);
`endif

    // Sweep timeout on every attempt -> ERROR
    rb = restart_cnt;
    do_start();
    for (int n = 0; n < 5 * SWEEP_TO + 100 && error !== 1'b1; n++) tick();
    check("swto_error", {31'd0, error}, 32'd1);
    check("swto_restarts", 32'(restart_cnt - rb), 32'd4);
    check("swto_retry", {30'd0, retry_cnt}, 32'd3);
    tick();
    check("swto_idle_busy_err", {30'd0, busy, error}, 32'b01);
    do_start();
    check("swto_restart_clears", {29'd0, busy, error, retry_cnt == 2'd0}, 32'b101);
    do_abort();

    // Sync timeout, then success on the retry
    bb = rx_bytes.size(); db = done_cnt;
    do_start();
    repeat (5) tick();
    pulse_sweep();
    rb = restart_cnt;
    for (int i = 0; i < 256; i++) send_bit(i[0] == 1'b0);
    check("synto_restarts", 32'(restart_cnt - rb), 32'd1);
    check("synto_retry", {30'd0, retry_cnt}, 32'd1);
    check("synto_back_in_sweep", {30'd0, mix_en, demod_start}, 32'b10);
    pulse_sweep();
    send_word(16'h2DD4);
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    wait_done(db, 50);
    repeat (2) tick();
    check_bytes("synto", bb, 8'hA0, 8);
    check("synto_done_pulses", 32'(done_cnt - db), 32'd1);

    // Sync straddling HUNT entry must not match
    bb = rx_bytes.size(); db = done_cnt;
    do_start();
    repeat (3) tick();
    send_byte(8'h2D);
    pulse_sweep();
    send_byte(8'hD4);
    check("strad_no_bytes", 32'(rx_bytes.size() - bb), 32'd0);
    send_word(16'h2DD4);
    for (int i = 0; i < 8; i++) send_byte(8'h51 + 8'(i));
    wait_done(db, 50);
    repeat (2) tick();
    check_bytes("strad", bb, 8'h51, 8);
    check("strad_done_pulses", 32'(done_cnt - db), 32'd1);

    // Abort during RECV after three bytes
    bb = rx_bytes.size(); db = done_cnt;
    do_start();
    repeat (2) tick();
    pulse_sweep();
    send_word(16'h2DD4);
    for (int i = 0; i < 3; i++) send_byte(8'h11 * 8'(i + 1));
    do_abort();
    check("abort_idle", {30'd0, busy, mix_en}, 32'd0);
    send_byte(8'h44);
    repeat (20) tick();
    check("abort_nbytes", 32'(rx_bytes.size() - bb), 32'd3);
    check("abort_no_done", 32'(done_cnt - db), 32'd0);
    check("abort_no_error", {31'd0, error}, 32'd0);
    do_start();
    check("abort_restart_ok", {31'd0, busy}, 32'd1);
    do_abort();

    // Reset mid-operation wins over a simultaneous start
    do_start();
    pulse_sweep();
    send_bit(1'b1);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("midrst_outputs",
          {21'd0, mix_en, demod_start, byte_valid, busy, done, error, retry_cnt, 1'b0,
           3'd0},
          32'd0);

`ifdef RX_SYNC_TOL_EN
    // Two-bit error rejected, one-bit error accepted and flagged
    bb = rx_bytes.size(); db = done_cnt;
    do_start();
    check("tol_sync_err_clear", {31'd0, sync_err}, 32'd0);
    pulse_sweep();
    send_word(16'h2DD7);
    check("tol_2bit_no_match", 32'(rx_bytes.size() - bb), 32'd0);
    send_word(16'h2DD5);
    for (int i = 0; i < 8; i++) send_byte(8'h61 + 8'(i));
    wait_done(db, 50);
    repeat (2) tick();
    check_bytes("tol", bb, 8'h61, 8);
    check("tol_sync_err", {31'd0, sync_err}, 32'd1);
    do_start();
    check("tol_sync_err_start_clr", {31'd0, sync_err}, 32'd0);
    do_abort();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/rx_seq_ctrl.md
Name: rx_seq_ctrl

Overview:
- Receive sequencer for the GMSK chain: enables the downmixer, waits for its frequency sweep, then starts the demodulator.
- Hunts the demodulated bitstream for a sync word, packs the payload into bytes, and retries or flags an error on timeout.
- Runs in the 6.4 MHz datapath clock domain, between the host/test control and the downmixer_recovery/demod_gmsk pair.

Parameters:
- SYNC_LEN, 16, sync word length in bits
- SYNC_WORD, 16'h2DD4, sync pattern; MSB is received first
- PAYLOAD_BYTES, 8, bytes collected after sync
- SWEEP_TIMEOUT, 640000, clk cycles allowed for sweep_done (100 ms)
- SYNC_TIMEOUT_BITS, 256, bit strobes allowed in HUNT before timeout
- MAX_RETRY, 3, number of retries before ERROR

Ports:
- clk  in  1  6.4 MHz clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a reception when idle
- abort  in  1  pulse; returns to IDLE from any state
- sweep_done  in  1  downmixer sweep-complete level/pulse
- bit_strobe  in  1  one-cycle pulse per demodulated bit, clk domain
- bit_in  in  1  demodulated bit, valid with bit_strobe
- mix_en  out  1  downmixer enable
- demod_start  out  1  demodulator start
- byte_data  out  8  payload byte
- byte_valid  out  1  one-cycle strobe for byte_data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky failure flag
- retry_cnt  out  2  retries used

Behaviour:
- All outputs are registered. On reset every output is 0 and the state is IDLE.
- States: IDLE, SWEEP, HUNT, RECV, RESTART, DONE, ERROR.
- IDLE: on start, go to SWEEP; clear error and retry_cnt; clear the timeout counter.
- SWEEP: mix_en=1. sweep_done=1 goes to HUNT. Counter reaching SWEEP_TIMEOUT-1 without sweep_done goes to RESTART. If both occur in the same cycle, sweep_done wins.
- HUNT: mix_en=1, demod_start=1.
  - Each bit_strobe shifts bit_in into a SYNC_LEN shift register (LSB side) and increments the bit counter.
  - Match is tested on the post-shift value, and only once bit counter ≥ SYNC_LEN.
  - A match goes to RECV. A bit counter reaching SYNC_TIMEOUT_BITS without a match goes to RESTART.
  - The shift register and counters clear on entry. A bit_strobe in the entry cycle is ignored.
- RECV: mix_en=1, demod_start=1.
  - Bits are packed MSB first.
  - After the 8th bit of a byte, byte_data/byte_valid are presented on the next cycle.
  - After PAYLOAD_BYTES bytes, go to DONE. No timeout in RECV.
- RESTART: one cycle with mix_en=0 and demod_start=0 to reinitialise the datapath.
  - If retry_cnt==MAX_RETRY, go to ERROR; otherwise retry_cnt++ and go to SWEEP.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: error=1 (sticky), mix_en=0, next state IDLE. error is cleared only by the next accepted start or by rst.
- abort overrides all other transitions: next state is IDLE, and no done or byte_valid is issued afterwards. error is not set. abort with start in the same cycle: abort wins and start is dropped.
- start while busy is ignored.
- rst mid-operation returns to the reset state on the next edge, regardless of any other input.
- retry_cnt saturates at MAX_RETRY. Counter widths are $clog2 of the respective limits.

Optional Feature:
- RX_SYNC_TOL_EN defined: HUNT also accepts a Hamming distance of ≤1 between the shift register and SYNC_WORD.
- Output sync_err (1 bit) is added: it is registered at the moment of match and holds 1 if the match was inexact. It is cleared on start.
- Without the macro: exact match only, and the sync_err port is absent.

Decomposition:
- Package rx_seq_pkg holds:
  - the state enum rx_state_t (3 bits)
  - the default SYNC_WORD/SYNC_LEN constants
  - a function popcount16 used for sync tolerance.
- One natural sub-module, rx_bit_packer: a shift register plus 3-bit counter producing byte_data/byte_valid, with a clear input. It is instantiated in RECV; the HUNT shift register is separate.

Test Plan:
- Nominal: start; sweep_done after 1000 cycles; bits 0x2DD4 then 0x01..0x08 → 8 byte_valid pulses carrying 0x01..0x08, then done. retry_cnt=0.
- Sweep timeout: start, sweep_done never asserted → 4 RESTART cycles with mix_en low, retry_cnt=3, error=1 after 4×640000+ cycles, busy=0.
- Sync timeout then success: 256 random bits without the pattern → RESTART, retry_cnt=1; second attempt with the sync → done, payload correct.
- Pattern straddling HUNT entry: sync bits beginning before sweep_done → no false match; sync must be re-sent in full.
- Abort during RECV after 3 bytes → IDLE next cycle, no further byte_valid, no done, error=0; a later start is accepted.
- Macro on: sync 0x2DD5 (1-bit error) → RECV, sync_err=1. With 0x2DD7 (2-bit error) → no match.
